// File: rtl/card_pkg.sv
// Shared constants and types for the card sprite renderer.
package card_pkg;

  localparam int unsigned SCREEN_W    = 256;
  localparam int unsigned SCREEN_H    = 240;
  localparam int unsigned CARD_W      = 16;
  localparam int unsigned CARD_H      = 32;
  localparam int unsigned CARD_ADDR_W = 9;
  localparam int unsigned COLOR_W     = 3;

  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic       vis;
  } card_pos_t;

endpackage

// File: rtl/card_pixel_renderer_if.sv
// Read port between the renderer and the card sprite memory.
interface card_pixel_renderer_if;
  import card_pkg::*;

  logic [CARD_ADDR_W-1:0] rAddr;
  logic                   RE;
  color_t                 ram_data;

  modport master (output rAddr, output RE, input ram_data);
  modport slave  (input rAddr, input RE, output ram_data);

endinterface

// File: rtl/card_pos_shadow.sv
// Double-buffered card position: updates land in a shadow copy and move to the
// active copy only on frame_start so a frame is never drawn with mixed positions.
module card_pos_shadow
  import card_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      pos_valid,
  input  logic      frame_start,
  input  card_pos_t pos_in,
  output card_pos_t act,
  output logic      pos_pending
);

  card_pos_t shadow_q;
  card_pos_t act_q;
  logic      pending_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q  <= '0;
      act_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      if (pos_valid) begin
        shadow_q <= pos_in;
      end
      if (frame_start) begin
        // A strobe coinciding with frame start bypasses the shadow.
        if (pos_valid) begin
          act_q <= pos_in;
        end else if (pending_q) begin
          act_q <= shadow_q;
        end
        pending_q <= 1'b0;
      end else if (pos_valid) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign act         = act_q;
  assign pos_pending = pending_q;

endmodule

// File: rtl/card_pixel_renderer.sv
// Card sprite pixel pipeline: hit test and texel addressing, memory-latency
// alignment, transparency substitution. Two clocks from hcount to pix_color.
module card_pixel_renderer
  import card_pkg::*;
#(
  parameter int unsigned CARD_W     = 16,
  parameter int unsigned CARD_H     = 32,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter color_t      TRANSP     = 3'b000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [8:0]            hcount,
  input  logic [8:0]            vcount,
  input  logic                  video_on,
  input  logic                  frame_start,
  input  logic [8:0]            pos_x_in,
  input  logic [8:0]            pos_y_in,
  input  logic                  vis_in,
  input  logic                  pos_valid,
  input  color_t                bg_color,
  card_pixel_renderer_if.master mem,
  output color_t                pix_color,
  output logic                  pix_valid,
  output logic                  pos_pending
);

  localparam int unsigned CardWLog2 = $clog2(CARD_W);
  localparam int unsigned CardHLog2 = $clog2(CARD_H);
  localparam logic signed [9:0] SpanX = 10'(CARD_W << SCALE_LOG2);
  localparam logic signed [9:0] SpanY = 10'(CARD_H << SCALE_LOG2);

  card_pos_t pos_req;
  card_pos_t act;

  assign pos_req = '{x: pos_x_in, y: pos_y_in, vis: vis_in};

  card_pos_shadow u_pos_shadow (
    .clock       (clock),
    .reset       (reset),
    .pos_valid   (pos_valid),
    .frame_start (frame_start),
    .pos_in      (pos_req),
    .act         (act),
    .pos_pending (pos_pending)
  );

  logic signed [9:0]      dx;
  logic signed [9:0]      dy;
  logic                   inbox;
  logic [CardWLog2-1:0]   tx;
  logic [CardHLog2-1:0]   ty;
  logic [CARD_ADDR_W-1:0] addr_c;

  always_comb begin
    dx    = $signed({1'b0, hcount}) - $signed({1'b0, act.x});
    dy    = $signed({1'b0, vcount}) - $signed({1'b0, act.y});
    inbox = act.vis & video_on & ~dx[9] & (dx < SpanX) & ~dy[9] & (dy < SpanY);
    // Inside the box dx/dy are non-negative, so the arithmetic shift is a slice.
    tx     = dx[SCALE_LOG2 +: CardWLog2];
    ty     = dy[SCALE_LOG2 +: CardHLog2];
    addr_c = {ty, tx};
  end

  logic [CARD_ADDR_W-1:0] raddr_q;
  logic                   re_q;
  logic                   vid_d1, vid_d2;
  logic                   inbox_d1, inbox_d2;
  color_t                 bg_d1, bg_d2;
  color_t                 pix_color_q;
  logic                   pix_valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      raddr_q     <= '0;
      re_q        <= 1'b0;
      vid_d1      <= 1'b0;
      vid_d2      <= 1'b0;
      inbox_d1    <= 1'b0;
      inbox_d2    <= 1'b0;
      bg_d1       <= '0;
      bg_d2       <= '0;
      pix_color_q <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      if (inbox) begin
        raddr_q <= addr_c;
      end
      re_q     <= inbox;
      vid_d1   <= video_on;
      inbox_d1 <= inbox;
      bg_d1    <= bg_color;

      vid_d2   <= vid_d1;
      inbox_d2 <= inbox_d1;
      bg_d2    <= bg_d1;

      pix_valid_q <= vid_d2;
      if (!vid_d2) begin
        pix_color_q <= '0;
      end else if (!inbox_d2 || (mem.ram_data == TRANSP)) begin
        pix_color_q <= bg_d2;
      end else begin
        pix_color_q <= mem.ram_data;
      end
    end
  end

  assign mem.rAddr = raddr_q;
  assign mem.RE    = re_q;
  assign pix_color = pix_color_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_card_pixel_renderer.sv
// Directed bench for card_pixel_renderer with a registered-read sprite memory
// model holding ram[i] = i % 8.
module tb_card_pixel_renderer;
  import card_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [8:0] hcount, vcount;
  logic       video_on, frame_start;
  logic [8:0] pos_x_in, pos_y_in;
  logic       vis_in, pos_valid;
  color_t     bg_color;
  color_t     pix_color;
  logic       pix_valid, pos_pending;

  card_pixel_renderer_if mem ();

  card_pixel_renderer dut (
    .clock       (clock),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .video_on    (video_on),
    .frame_start (frame_start),
    .pos_x_in    (pos_x_in),
    .pos_y_in    (pos_y_in),
    .vis_in      (vis_in),
    .pos_valid   (pos_valid),
    .bg_color    (bg_color),
    .mem         (mem),
    .pix_color   (pix_color),
    .pix_valid   (pix_valid),
    .pos_pending (pos_pending)
  );

  always #5 clock = ~clock;

  color_t ram [512];

  always @(posedge clock) begin
    if (reset) mem.ram_data <= '0;
    else if (mem.RE) mem.ram_data <= ram[mem.rAddr];
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pos(input logic [8:0] x, input logic [8:0] y, input logic v,
                         input logic fs);
    pos_x_in = x; pos_y_in = y; vis_in = v; pos_valid = 1'b1; frame_start = fs;
    tick();
    pos_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // One visible pixel followed by two blank cycles so its colour surfaces alone.
  task automatic probe(input string tag, input logic [8:0] h, input logic [8:0] v,
                       input color_t bg, input logic exp_re, input logic [8:0] exp_addr,
                       input color_t exp_col);
    hcount = h; vcount = v; video_on = 1'b1; bg_color = bg;
    tick();
    check({tag, ".re"}, mem.RE, exp_re);
    check({tag, ".addr"}, mem.rAddr, exp_addr);
    video_on = 1'b0; hcount = '0; bg_color = '0;
    tick();
    check({tag, ".early"}, pix_color, 0);
    tick();
    check({tag, ".col"}, pix_color, exp_col);
    check({tag, ".valid"}, pix_valid, 1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = color_t'(i % 8);
    reset = 1'b1; hcount = '0; vcount = '0; video_on = 1'b0; frame_start = 1'b0;
    pos_x_in = '0; pos_y_in = '0; vis_in = 1'b0; pos_valid = 1'b0; bg_color = '0;
    tick(); tick();
    check("rst.addr", mem.rAddr, 0);
    check("rst.re", mem.RE, 0);
    check("rst.col", pix_color, 0);
    check("rst.valid", pix_valid, 0);
    check("rst.pend", pos_pending, 0);
    reset = 1'b0;

    // No card visible: RE stays low, pix_valid follows video_on two clocks late.
    for (int i = 0; i < 10; i++) begin
      hcount = 9'(i); video_on = 1'b1;
      tick();
      check("idle.re", mem.RE, 0);
      check("idle.valid", pix_valid, (i >= 2) ? 1 : 0);
      check("idle.col", pix_color, 0);
    end
    video_on = 1'b0;
    tick(); tick();

    // Mid-frame update stays in the shadow until frame_start.
    set_pos(9'd100, 9'd50, 1'b1, 1'b0);
    check("shadow.pend", pos_pending, 1);
    probe("pre", 9'd100, 9'd50, 3'd5, 1'b0, 9'd0, 3'd5);
    check("pre.pend", pos_pending, 1);
    pulse_frame();
    check("apply.pend", pos_pending, 0);

    probe("corner0", 9'd100, 9'd50, 3'd6, 1'b1, 9'd0, 3'd6);
    probe("corner511", 9'd131, 9'd113, 3'd2, 1'b1, 9'd511, 3'd7);
    probe("tex17", 9'd103, 9'd52, 3'd4, 1'b1, 9'd17, 3'd1);
    probe("redge_in", 9'd131, 9'd50, 3'd4, 1'b1, 9'd15, 3'd7);
    probe("redge_out", 9'd132, 9'd50, 3'd4, 1'b0, 9'd15, 3'd4);
    probe("bedge_out", 9'd100, 9'd114, 3'd3, 1'b0, 9'd15, 3'd3);
    probe("ledge_out", 9'd99, 9'd50, 3'd1, 1'b0, 9'd15, 3'd1);

    // Simultaneous strobe and frame start apply immediately.
    set_pos(9'd240, 9'd0, 1'b1, 1'b1);
    check("simul.pend", pos_pending, 0);
    probe("x240", 9'd240, 9'd0, 3'd2, 1'b1, 9'd0, 3'd2);
    probe("x255", 9'd255, 9'd0, 3'd2, 1'b1, 9'd7, 3'd7);
    for (int h = 256; h < 272; h += 5) begin
      hcount = 9'(h); vcount = '0; video_on = 1'b0;
      tick();
      check("offscr.re", mem.RE, 0);
      check("offscr.addr", mem.rAddr, 7);
    end
    tick(); tick();
    check("offscr.col", pix_color, 0);
    check("offscr.valid", pix_valid, 0);

    // Last write before frame_start wins.
    set_pos(9'd10, 9'd0, 1'b1, 1'b0);
    set_pos(9'd20, 9'd0, 1'b1, 1'b0);
    check("lww.pend", pos_pending, 1);
    pulse_frame();
    check("lww.pend2", pos_pending, 0);
    probe("lww.in", 9'd20, 9'd0, 3'd1, 1'b1, 9'd0, 3'd1);
    probe("lww.out", 9'd19, 9'd0, 3'd5, 1'b0, 9'd0, 3'd5);
    probe("lww.tex17", 9'd22, 9'd2, 3'd5, 1'b1, 9'd17, 3'd1);

    // Reset in the middle of a line.
    hcount = 9'd22; vcount = 9'd2; video_on = 1'b1; bg_color = 3'd3;
    tick();
    check("mid.re", mem.RE, 1);
    reset = 1'b1;
    tick();
    check("mid.rst.col", pix_color, 0);
    check("mid.rst.valid", pix_valid, 0);
    check("mid.rst.re", mem.RE, 0);
    check("mid.rst.addr", mem.rAddr, 0);
    check("mid.rst.pend", pos_pending, 0);
    reset = 1'b0;
    video_on = 1'b0;
    tick(); tick();
    pulse_frame();
    probe("post_rst", 9'd20, 9'd0, 3'd6, 1'b0, 9'd0, 3'd6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
